poly_result_buffer: RTL and testbench
=====================================

Name: poly_result_buffer

Overview:
- Downstream stage of the cubic polynomial pipeline.
- Captures each 6-bit pipeline result tagged by a valid strobe and queues it in a small first-word-fall-through FIFO.
- Presents queued results to the consumer over a valid/ready handshake.
- Keeps a saturating running sum of all accepted results, with sticky drop and saturation flags for debug.

Parameters:
- DATA_W, 6, width of a pipeline result (matches polynomial result width).
- DEPTH, 4, FIFO entries; power of two, >= 2.
- ACC_W, 12, running-sum width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  pipeline result valid this cycle.
- in_data  in  DATA_W  pipeline result value.
- clear  in  1  synchronous clear of FIFO, sum and flags.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head this cycle.
- out_data  out  DATA_W  head entry; FWFT.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- acc_sum  out  ACC_W  saturating sum of accepted results.
- acc_sat  out  1  sticky; acc_sum has saturated.
- drop_err  out  1  sticky; a result was discarded because the FIFO was full.

Behaviour:
- Reset (rst high, asynchronous) clears everything:
  - count, read pointer and write pointer = 0.
  - acc_sum = 0; acc_sat = 0; drop_err = 0.
  - out_valid = 0; empty = 1; full = 0.
  - out_data = 0 (storage array is also zeroed).
- Reset may assert mid-transfer. All in-flight entries are lost. Normal operation resumes on the first rising edge after deassertion.
- pop = out_valid && out_ready. Head pointer advances and count decrements at that edge.
- push = in_valid && (!full || pop). Data is written at the write pointer and count increments at that edge.
- Simultaneous push and pop:
  - Count is unchanged.
  - When full, the push is accepted (pop frees the slot in the same cycle).
  - When empty there is no pop (out_valid = 0), so only the push occurs.
- Drop: in_valid && full && !pop discards in_data, sets drop_err, and leaves acc_sum unchanged.
- Pointers wrap modulo DEPTH.
- FWFT latency: a value pushed at edge N drives out_data/out_valid after edge N, i.e. one cycle input-to-output when empty.
- out_data holds the head entry whenever out_valid = 1. Its value is don't-care when empty, but it must not be X after reset.
- Accumulator: on every accepted push, acc_sum <= min(acc_sum + zero-extended in_data, 2^ACC_W - 1).
  - When the clamp engages, acc_sat <= 1.
  - Once saturated, acc_sum holds at all-ones.
- clear (synchronous):
  - Empties the FIFO, zeroes acc_sum, and clears acc_sat and drop_err.
  - Overrides any push, pop or drop in the same cycle: input ignored, not flagged, and the head is not considered consumed.
- Flags are combinational from count: full = (count == DEPTH), empty = (count == 0), out_valid = !empty.
- There is no combinational path from in_valid/in_data to out_*. out_ready may combinationally affect nothing except internal push acceptance.

Test Plan:
- Reset then single push: rst pulse; in_valid=1, in_data=6'd27 for one cycle, out_ready=0 -> next cycle out_valid=1, out_data=27, count=1, acc_sum=27.
- Fill and drop: push 5,10,15,20 with out_ready=0, then push 33 -> full=1, count=4, drop_err=1, acc_sum=50; pop all 4 -> outputs 5,10,15,20 in order, empty=1.
- Full with simultaneous push/pop: full with 1,2,3,4; in_valid=1, in_data=9, out_ready=1 -> 1 consumed, 9 accepted, count stays 4, drop_err=0, next heads 2,3,4,9.
- Saturation: ACC_W=8; push 63 five times while popping continuously -> acc_sum=255 after the 5th push (252 after 4th), acc_sat=1; further pushes keep 255.
- Clear priority: count=3 with acc_sum=40; assert clear with in_valid=1 and out_ready=1 -> next cycle count=0, acc_sum=0, flags 0, pushed value absent.
- Async reset mid-stream: rst asserted between edges while count=2 -> outputs go to reset values immediately, without waiting for a clock edge; after release a push of 12 appears as out_data=12.

Source files
------------

// File: rtl/poly_result_buffer.sv
// Result buffer for the cubic polynomial pipeline: FWFT FIFO with valid/ready output,
// plus a saturating running sum of accepted results and sticky debug flags.
module poly_result_buffer #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4,
    parameter int ACC_W  = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic [ACC_W-1:0]           acc_sum,
    output logic                       acc_sat,
    output logic                       drop_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ACC_W-1:0]  r_acc;
    logic              r_sat;
    logic              r_drop;

    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [ACC_W:0]    w_sum;
    logic              w_clamp;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign out_valid = !empty;
    assign out_data  = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign acc_sum   = r_acc;
    assign acc_sat   = r_sat;
    assign drop_err  = r_drop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop  = out_valid && out_ready;
    assign w_push = in_valid && (!full || w_pop);
    assign w_drop = in_valid && full && !w_pop;

    // One extra bit catches the carry that signals the clamp.
    assign w_sum   = {1'b0, r_acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
    assign w_clamp = w_sum[ACC_W];

    // NOTE: the storage array sits in the reset branch so out_data is a known 0
    // after reset instead of X; this costs a reset net on every storage flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_acc    <= '0;
            r_sat    <= 1'b0;
            r_drop   <= 1'b0;
        end else if (clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_acc    <= '0;
            r_sat    <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                if (w_clamp) begin
                    r_acc <= '1;
                    r_sat <= 1'b1;
                end else begin
                    r_acc <= w_sum[ACC_W-1:0];
                end
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_drop) r_drop <= 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_result_buffer.sv
// Directed self-checking bench for poly_result_buffer (default ACC_W and an 8-bit-sum copy).
module tb_poly_result_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [5:0] in_data;
    logic       clear;
    logic       out_ready;

    logic       out_valid,  out_valid8;
    logic [5:0] out_data,   out_data8;
    logic [2:0] count,      count8;
    logic       full,       full8;
    logic       empty,      empty8;
    logic [11:0] acc_sum;
    logic [7:0]  acc_sum8;
    logic       acc_sat,    acc_sat8;
    logic       drop_err,   drop_err8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    poly_result_buffer #(.DATA_W(6), .DEPTH(4), .ACC_W(12)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count),
        .full(full), .empty(empty), .acc_sum(acc_sum), .acc_sat(acc_sat), .drop_err(drop_err)
    );

    poly_result_buffer #(.DATA_W(6), .DEPTH(4), .ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8), .count(count8),
        .full(full8), .empty(empty8), .acc_sum(acc_sum8), .acc_sat(acc_sat8), .drop_err(drop_err8)
    );

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        #12;
        rst = 1'b0;
        step();
    endtask

    task automatic push(input logic [5:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++; if (empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_flags got e=%b f=%b v=%b exp e=1 f=0 v=0", empty, full, out_valid); end
        n_checks++; if (out_data !== 6'd0) begin n_fail++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        n_checks++; if (acc_sum !== 12'd0 || acc_sat !== 1'b0 || drop_err !== 1'b0) begin n_fail++; $display("FAIL reset_acc got sum=%0d sat=%b drop=%b exp 0/0/0", acc_sum, acc_sat, drop_err); end
    endtask

    task automatic test_single_push();
        do_reset();
        push(6'd27);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 6'd27) begin n_fail++; $display("FAIL single_head got v=%b d=%0d exp v=1 d=27", out_valid, out_data); end
        n_checks++; if (count !== 3'd1 || acc_sum !== 12'd27) begin n_fail++; $display("FAIL single_count_sum got c=%0d s=%0d exp c=1 s=27", count, acc_sum); end
    endtask

    task automatic test_fill_drop();
        logic [5:0] exp_q [4];
        exp_q = '{6'd5, 6'd10, 6'd15, 6'd20};
        do_reset();
        for (int i = 0; i < 4; i++) push(exp_q[i]);
        n_checks++; if (drop_err !== 1'b0 || full !== 1'b1) begin n_fail++; $display("FAIL fill_pre_drop got drop=%b full=%b exp drop=0 full=1", drop_err, full); end
        push(6'd33);
        n_checks++; if (full !== 1'b1 || count !== 3'd4 || drop_err !== 1'b1) begin n_fail++; $display("FAIL drop_flags got f=%b c=%0d d=%b exp f=1 c=4 d=1", full, count, drop_err); end
        n_checks++; if (acc_sum !== 12'd50) begin n_fail++; $display("FAIL drop_acc got=%0d exp=50", acc_sum); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin n_fail++; $display("FAIL drain_%0d got v=%b d=%0d exp v=1 d=%0d", i, out_valid, out_data, exp_q[i]); end
            step();
        end
        out_ready = 1'b0;
        n_checks++; if (empty !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL drain_empty got e=%b v=%b c=%0d exp e=1 v=0 c=0", empty, out_valid, count); end
    endtask

    task automatic test_full_push_pop();
        logic [5:0] exp_q [4];
        exp_q = '{6'd2, 6'd3, 6'd4, 6'd9};
        do_reset();
        for (int i = 1; i <= 4; i++) push(6'(i));
        in_valid  = 1'b1;
        in_data   = 6'd9;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (count !== 3'd4 || full !== 1'b1 || drop_err !== 1'b0) begin n_fail++; $display("FAIL fullpp_flags got c=%0d f=%b d=%b exp c=4 f=1 d=0", count, full, drop_err); end
        n_checks++; if (acc_sum !== 12'd19) begin n_fail++; $display("FAIL fullpp_acc got=%0d exp=19", acc_sum); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_data !== exp_q[i]) begin n_fail++; $display("FAIL fullpp_head_%0d got=%0d exp=%0d", i, out_data, exp_q[i]); end
            step();
        end
        out_ready = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fullpp_empty got=%b exp=1", empty); end
    endtask

    task automatic test_saturation();
        logic [7:0] exp_sum [7];
        exp_sum = '{8'd63, 8'd126, 8'd189, 8'd252, 8'd255, 8'd255, 8'd255};
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 6'd63;
        for (int i = 0; i < 7; i++) begin
            step();
            n_checks++; if (acc_sum8 !== exp_sum[i]) begin n_fail++; $display("FAIL sat_sum_%0d got=%0d exp=%0d", i, acc_sum8, exp_sum[i]); end
            n_checks++; if (acc_sat8 !== (i >= 4)) begin n_fail++; $display("FAIL sat_flag_%0d got=%b exp=%b", i, acc_sat8, (i >= 4)); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (acc_sum !== 12'd441 || acc_sat !== 1'b0) begin n_fail++; $display("FAIL sat_wide got s=%0d sat=%b exp s=441 sat=0", acc_sum, acc_sat); end
    endtask

    task automatic test_clear();
        do_reset();
        push(6'd10);
        push(6'd20);
        push(6'd10);
        n_checks++; if (count !== 3'd3 || acc_sum !== 12'd40) begin n_fail++; $display("FAIL clear_pre got c=%0d s=%0d exp c=3 s=40", count, acc_sum); end
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 6'd7;
        out_ready = 1'b1;
        step();
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (count !== 3'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_fifo got c=%0d e=%b v=%b exp c=0 e=1 v=0", count, empty, out_valid); end
        n_checks++; if (acc_sum !== 12'd0 || acc_sat !== 1'b0 || drop_err !== 1'b0) begin n_fail++; $display("FAIL clear_acc got s=%0d sat=%b d=%b exp 0/0/0", acc_sum, acc_sat, drop_err); end
        push(6'd11);
        n_checks++; if (count !== 3'd1 || out_data !== 6'd11 || acc_sum !== 12'd11) begin n_fail++; $display("FAIL clear_after got c=%0d d=%0d s=%0d exp c=1 d=11 s=11", count, out_data, acc_sum); end
    endtask

    task automatic test_async_reset();
        do_reset();
        push(6'd3);
        push(6'd8);
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL async_pre got c=%0d exp=2", count); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (count !== 3'd0 || out_valid !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL async_flags got c=%0d v=%b e=%b exp c=0 v=0 e=1", count, out_valid, empty); end
        n_checks++; if (out_data !== 6'd0 || acc_sum !== 12'd0) begin n_fail++; $display("FAIL async_data got d=%0d s=%0d exp d=0 s=0", out_data, acc_sum); end
        #1;
        rst = 1'b0;
        push(6'd12);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 6'd12 || count !== 3'd1) begin n_fail++; $display("FAIL async_after got v=%b d=%0d c=%0d exp v=1 d=12 c=1", out_valid, out_data, count); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_single_push();
        test_fill_drop();
        test_full_push_pop();
        test_saturation();
        test_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
